// File: rtl/lock_chamber_ctrl.sv
// Boat lock sequencer: two gates, fill/drain pumps and harbour occupancy.
// Each dwell state holds for an exact cycle count set by a reload down-counter.
module lock_chamber_ctrl #(
  parameter int DOOR_CYCLES  = 4,
  parameter int FILL_CYCLES  = 6,
  parameter int DRAIN_CYCLES = 5,
  parameter int MAX_BOATS    = 2,
  localparam int MAX_DWELL   = (DOOR_CYCLES > FILL_CYCLES)
                               ? ((DOOR_CYCLES > DRAIN_CYCLES) ? DOOR_CYCLES : DRAIN_CYCLES)
                               : ((FILL_CYCLES > DRAIN_CYCLES) ? FILL_CYCLES : DRAIN_CYCLES),
  localparam int CNT_W       = $clog2(MAX_DWELL + 1),
  localparam int OCC_W       = $clog2(MAX_BOATS + 1)
) (
  input  logic             timer,
  input  logic             rst,
  input  logic             arrive_req,
  input  logic             leave_req,
  output logic             outer_port,
  output logic             inner_port,
  output logic             pressure_up,
  output logic             pressure_down,
  output logic             arrive_done,
  output logic             leave_done,
  output logic [OCC_W-1:0] boat_count,
  output logic [2:0]       state
);

  // state      | meaning
  // LOW_IDLE   | chamber at outer level, gates closed, waiting
  // OUTER_OPEN | outer gate open
  // FILL       | raising chamber to inner level
  // INNER_OPEN | inner gate open
  // HIGH_IDLE  | chamber at inner level, gates closed, waiting
  // DRAIN      | lowering chamber to outer level
  typedef enum logic [2:0] {
    LOW_IDLE   = 3'd0,
    OUTER_OPEN = 3'd1,
    FILL       = 3'd2,
    INNER_OPEN = 3'd3,
    HIGH_IDLE  = 3'd4,
    DRAIN      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_ARR  = 2'd1,
    MODE_DEP  = 2'd2
  } mode_e;

  localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [OCC_W-1:0] MAX_OCC    = OCC_W'(MAX_BOATS);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               arr_pend_q, arr_pend_d;
  logic               lv_pend_q, lv_pend_d;
  logic               arr_prev_q, arr_prev_d;
  logic               lv_prev_q, lv_prev_d;
  logic               arrive_done_q, arrive_done_d;
  logic               leave_done_q, leave_done_d;

  logic dwell_done;
  logic arr_clr;
  logic lv_clr;
  logic room;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    count_d       = count_q;
    arr_pend_d    = arr_pend_q;
    lv_pend_d     = lv_pend_q;
    arr_prev_d    = arrive_req;
    lv_prev_d     = leave_req;
    arrive_done_d = 1'b0;
    leave_done_d  = 1'b0;
    arr_clr       = 1'b0;
    lv_clr        = 1'b0;
    dwell_done    = (cnt_q == '0);
    room          = (count_q < MAX_OCC);

    case (state_q)
      LOW_IDLE: begin
        if (arr_pend_q && room) begin
          state_d = OUTER_OPEN;
          mode_d  = MODE_ARR;
          cnt_d   = DOOR_LOAD;
        end else if (lv_pend_q) begin
          state_d = FILL;
          mode_d  = MODE_NONE;
          cnt_d   = FILL_LOAD;
        end
      end
      OUTER_OPEN: begin
        if (!dwell_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mode_q == MODE_ARR) begin
          state_d = FILL;
          cnt_d   = FILL_LOAD;
        end else begin
          state_d = LOW_IDLE;
          mode_d  = MODE_NONE;
          if (mode_q == MODE_DEP) begin
            if (count_q != '0) count_d = count_q - 1'b1;
            leave_done_d = 1'b1;
            lv_clr       = 1'b1;
          end
        end
      end
      FILL: begin
        if (!dwell_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mode_q == MODE_ARR) begin
          state_d = INNER_OPEN;
          cnt_d   = DOOR_LOAD;
        end else begin
          state_d = HIGH_IDLE;
          mode_d  = MODE_NONE;
        end
      end
      INNER_OPEN: begin
        if (!dwell_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mode_q == MODE_DEP) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = HIGH_IDLE;
          mode_d  = MODE_NONE;
          if (mode_q == MODE_ARR) begin
            if (room) count_d = count_q + 1'b1;
            arrive_done_d = 1'b1;
            arr_clr       = 1'b1;
          end
        end
      end
      HIGH_IDLE: begin
        if (lv_pend_q) begin
          state_d = INNER_OPEN;
          mode_d  = MODE_DEP;
          cnt_d   = DOOR_LOAD;
        end else if (arr_pend_q && room) begin
          state_d = DRAIN;
          mode_d  = MODE_NONE;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!dwell_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mode_q == MODE_DEP) begin
          state_d = OUTER_OPEN;
          cnt_d   = DOOR_LOAD;
        end else begin
          state_d = LOW_IDLE;
          mode_d  = MODE_NONE;
        end
      end
      default: begin
        state_d = LOW_IDLE;
        mode_d  = MODE_NONE;
        cnt_d   = '0;
      end
    endcase

    // The clear from a completing cycle wins over a coincident new edge.
    if (arrive_req && !arr_prev_q && !arr_pend_q) arr_pend_d = 1'b1;
    if (arr_clr) arr_pend_d = 1'b0;
    if (leave_req && !lv_prev_q && !lv_pend_q && (count_q != '0)) lv_pend_d = 1'b1;
    if (lv_clr) lv_pend_d = 1'b0;
  end

  always_ff @(posedge timer or negedge rst) begin
    if (!rst) begin
      state_q       <= LOW_IDLE;
      mode_q        <= MODE_NONE;
      cnt_q         <= '0;
      count_q       <= '0;
      arr_pend_q    <= 1'b0;
      lv_pend_q     <= 1'b0;
      arr_prev_q    <= 1'b0;
      lv_prev_q     <= 1'b0;
      arrive_done_q <= 1'b0;
      leave_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      count_q       <= count_d;
      arr_pend_q    <= arr_pend_d;
      lv_pend_q     <= lv_pend_d;
      arr_prev_q    <= arr_prev_d;
      lv_prev_q     <= lv_prev_d;
      arrive_done_q <= arrive_done_d;
      leave_done_q  <= leave_done_d;
    end
  end

  assign outer_port    = (state_q == OUTER_OPEN);
  assign inner_port    = (state_q == INNER_OPEN);
  assign pressure_up   = (state_q == FILL);
  assign pressure_down = (state_q == DRAIN);
  assign arrive_done   = arrive_done_q;
  assign leave_done    = leave_done_q;
  assign boat_count    = count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Bench for lock_chamber_ctrl: directed vector table, hand-written corner
// sequences, then random requests checked against a trip-queue model.
module tb_lock_chamber_ctrl;

  localparam int D   = 4;
  localparam int F   = 6;
  localparam int DR  = 5;
  localparam int MAX = 2;

  logic       timer;
  logic       rst;
  logic       arrive_req;
  logic       leave_req;
  logic       outer_port;
  logic       inner_port;
  logic       pressure_up;
  logic       pressure_down;
  logic       arrive_done;
  logic       leave_done;
  logic [1:0] boat_count;
  logic [2:0] state;

  int n_vec;
  int n_bad;

  lock_chamber_ctrl #(
    .DOOR_CYCLES (D),
    .FILL_CYCLES (F),
    .DRAIN_CYCLES(DR),
    .MAX_BOATS   (MAX)
  ) dut (
    .timer        (timer),
    .rst          (rst),
    .arrive_req   (arrive_req),
    .leave_req    (leave_req),
    .outer_port   (outer_port),
    .inner_port   (inner_port),
    .pressure_up  (pressure_up),
    .pressure_down(pressure_down),
    .arrive_done  (arrive_done),
    .leave_done   (leave_done),
    .boat_count   (boat_count),
    .state        (state)
  );

  initial timer = 1'b0;
  always #5 timer = ~timer;

  task automatic check(input string name, input int st, input int cnt, input bit ad, input bit ld);
    logic [3:0] exp_g;
    logic [3:0] got_g;
    exp_g = {st == 1, st == 3, st == 2, st == 5};
    got_g = {outer_port, inner_port, pressure_up, pressure_down};
    n_vec++;
    if (got_g !== exp_g || int'(state) != st || int'(boat_count) != cnt ||
        arrive_done !== ad || leave_done !== ld) begin
      n_bad++;
      $display("FAIL %s t=%0t got st=%0d cnt=%0d gates=%b ad=%b ld=%b, expected st=%0d cnt=%0d gates=%b ad=%b ld=%b",
               name, $time, state, boat_count, got_g, arrive_done, leave_done,
               st, cnt, exp_g, ad, ld);
    end
  endtask

  task automatic run(input string name, input bit a, input bit l, input int reps,
                     input int st, input int cnt, input bit ad, input bit ld);
    arrive_req = a;
    leave_req  = l;
    for (int i = 0; i < reps; i++) begin
      @(posedge timer);
      #1;
      check(name, st, cnt, ad, ld);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    arrive_req = 1'b0;
    leave_req  = 1'b0;
    repeat (2) @(posedge timer);
    @(negedge timer);
    rst = 1'b1;
  endtask

  // Reference model: each serviced request is a "trip", a queue of
  // per-cycle state codes whose completion applies the trip's effects.
  localparam int TRIP_REPOS = 0;
  localparam int TRIP_ARR   = 1;
  localparam int TRIP_DEP   = 2;

  int m_plan[$];
  int m_trip;
  int m_count;
  bit m_high, m_apend, m_lpend, m_aprev, m_lprev, m_ad, m_ld;

  task automatic model_reset();
    m_plan.delete();
    m_trip  = TRIP_REPOS;
    m_count = 0;
    m_high  = 1'b0;
    m_apend = 1'b0;
    m_lpend = 1'b0;
    m_aprev = 1'b0;
    m_lprev = 1'b0;
    m_ad    = 1'b0;
    m_ld    = 1'b0;
  endtask

  task automatic push_n(input int code, input int n);
    for (int i = 0; i < n; i++) m_plan.push_back(code);
  endtask

  task automatic model_step(input bit a, input bit l);
    bit old_ap, old_lp, aclr, lclr;
    int old_cnt;
    old_ap  = m_apend;
    old_lp  = m_lpend;
    old_cnt = m_count;
    aclr    = 1'b0;
    lclr    = 1'b0;
    m_ad    = 1'b0;
    m_ld    = 1'b0;
    if (m_plan.size() > 0) begin
      m_plan.delete(0);
      if (m_plan.size() == 0) begin
        if (m_trip == TRIP_ARR) begin
          if (m_count < MAX) m_count++;
          m_ad = 1'b1; aclr = 1'b1; m_high = 1'b1;
        end else if (m_trip == TRIP_DEP) begin
          if (m_count > 0) m_count--;
          m_ld = 1'b1; lclr = 1'b1; m_high = 1'b0;
        end else begin
          m_high = !m_high;
        end
      end
    end else if (!m_high) begin
      if (old_ap && old_cnt < MAX) begin
        push_n(1, D); push_n(2, F); push_n(3, D); m_trip = TRIP_ARR;
      end else if (old_lp) begin
        push_n(2, F); m_trip = TRIP_REPOS;
      end
    end else begin
      if (old_lp) begin
        push_n(3, D); push_n(5, DR); push_n(1, D); m_trip = TRIP_DEP;
      end else if (old_ap && old_cnt < MAX) begin
        push_n(5, DR); m_trip = TRIP_REPOS;
      end
    end
    if (a && !m_aprev && !old_ap) m_apend = 1'b1;
    if (aclr) m_apend = 1'b0;
    if (l && !m_lprev && !old_lp && old_cnt > 0) m_lpend = 1'b1;
    if (lclr) m_lpend = 1'b0;
    m_aprev = a;
    m_lprev = l;
  endtask

  function automatic int model_state();
    if (m_plan.size() > 0) return m_plan[0];
    return m_high ? 4 : 0;
  endfunction

  typedef struct {
    bit a;
    bit l;
    int reps;
    int st;
    int cnt;
    bit ad;
    bit ld;
  } vec_t;

  vec_t tbl[26];
  bit   ra, rl;

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Arrival from reset, second arrival via drain, full harbour, departure
    // then the held arrival is serviced.
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 4, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 6, 2, 0, 0, 0};
    tbl[3]  = '{1, 0, 4, 3, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 4, 1, 1, 0};
    tbl[5]  = '{0, 0, 2, 4, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 4, 1, 0, 0};
    tbl[7]  = '{1, 0, 5, 5, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 4, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 6, 2, 1, 0, 0};
    tbl[11] = '{1, 0, 4, 3, 1, 0, 0};
    tbl[12] = '{1, 0, 1, 4, 2, 1, 0};
    tbl[13] = '{0, 0, 2, 4, 2, 0, 0};
    tbl[14] = '{1, 0, 1, 4, 2, 0, 0};
    tbl[15] = '{1, 0, 3, 4, 2, 0, 0};
    tbl[16] = '{0, 1, 1, 4, 2, 0, 0};
    tbl[17] = '{0, 1, 4, 3, 2, 0, 0};
    tbl[18] = '{0, 1, 5, 5, 2, 0, 0};
    tbl[19] = '{0, 1, 4, 1, 2, 0, 0};
    tbl[20] = '{0, 1, 1, 0, 1, 0, 1};
    tbl[21] = '{0, 0, 4, 1, 1, 0, 0};
    tbl[22] = '{0, 0, 6, 2, 1, 0, 0};
    tbl[23] = '{0, 0, 4, 3, 1, 0, 0};
    tbl[24] = '{0, 0, 1, 4, 2, 1, 0};
    tbl[25] = '{0, 0, 2, 4, 2, 0, 0};

    rst        = 1'b0;
    arrive_req = 1'b0;
    leave_req  = 1'b0;
    #12;
    check("reset_state", 0, 0, 0, 0);
    @(negedge timer);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      run($sformatf("table_%0d", i), tbl[i].a, tbl[i].l, tbl[i].reps,
          tbl[i].st, tbl[i].cnt, tbl[i].ad, tbl[i].ld);
    end

    // Depart from HIGH_IDLE with two boats, leaving one boat at the low side.
    run("dep_high", 0, 1, 1, 4, 2, 0, 0);
    run("dep_high", 0, 1, 4, 3, 2, 0, 0);
    run("dep_high", 0, 0, 5, 5, 2, 0, 0);
    run("dep_high", 0, 0, 4, 1, 2, 0, 0);
    run("dep_high", 0, 0, 1, 0, 1, 0, 1);
    run("dep_high", 0, 0, 2, 0, 1, 0, 0);

    // Departure starting from LOW_IDLE with one boat.
    run("dep_low", 0, 1, 1, 0, 1, 0, 0);
    run("dep_low", 0, 1, 6, 2, 1, 0, 0);
    run("dep_low", 0, 1, 1, 4, 1, 0, 0);
    run("dep_low", 0, 1, 4, 3, 1, 0, 0);
    run("dep_low", 0, 0, 5, 5, 1, 0, 0);
    run("dep_low", 0, 0, 4, 1, 1, 0, 0);
    run("dep_low", 0, 0, 1, 0, 0, 0, 1);
    run("dep_low", 0, 0, 2, 0, 0, 0, 0);

    // Leave request with an empty harbour is dropped.
    run("leave_empty", 0, 1, 5, 0, 0, 0, 0);
    run("leave_empty", 0, 0, 2, 0, 0, 0, 0);

    // One boat in, then simultaneous requests in HIGH_IDLE: departure first.
    run("setup_one", 1, 0, 1, 0, 0, 0, 0);
    run("setup_one", 1, 0, 4, 1, 0, 0, 0);
    run("setup_one", 1, 0, 6, 2, 0, 0, 0);
    run("setup_one", 1, 0, 4, 3, 0, 0, 0);
    run("setup_one", 1, 0, 1, 4, 1, 1, 0);
    run("setup_one", 0, 0, 2, 4, 1, 0, 0);
    run("both_req", 1, 1, 1, 4, 1, 0, 0);
    run("both_req", 1, 1, 4, 3, 1, 0, 0);
    run("both_req", 0, 0, 5, 5, 1, 0, 0);
    run("both_req", 0, 0, 4, 1, 1, 0, 0);
    run("both_req", 0, 0, 1, 0, 0, 0, 1);
    run("both_req", 0, 0, 4, 1, 0, 0, 0);
    run("both_req", 0, 0, 6, 2, 0, 0, 0);
    run("both_req", 0, 0, 4, 3, 0, 0, 0);
    run("both_req", 0, 0, 1, 4, 1, 1, 0);
    run("both_req", 0, 0, 2, 4, 1, 0, 0);

    // Asynchronous reset in the middle of FILL.
    run("pre_rst", 1, 0, 1, 4, 1, 0, 0);
    run("pre_rst", 1, 0, 5, 5, 1, 0, 0);
    run("pre_rst", 1, 0, 1, 0, 1, 0, 0);
    run("pre_rst", 1, 0, 4, 1, 1, 0, 0);
    run("pre_rst", 1, 0, 3, 2, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0);
    @(posedge timer);
    #1;
    check("rst_held", 0, 0, 0, 0);
    @(negedge timer);
    rst        = 1'b1;
    arrive_req = 1'b0;
    run("post_rst", 0, 0, 2, 0, 0, 0, 0);
    run("post_rst", 1, 0, 1, 0, 0, 0, 0);
    run("post_rst", 1, 0, 4, 1, 0, 0, 0);
    run("post_rst", 1, 0, 1, 2, 0, 0, 0);

    // Random requests against the trip-queue model.
    do_reset();
    model_reset();
    ra = 1'b0;
    rl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) ra = ~ra;
      if ($urandom_range(7) == 0) rl = ~rl;
      arrive_req = ra;
      leave_req  = rl;
      @(posedge timer);
      model_step(ra, rl);
      #1;
      check("random", model_state(), m_count, m_ad, m_ld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
